// File: rtl/fifo_stream_reader.sv
// Read-side consumer for synchronous_fifo: turns the FIFO read port into a valid/ready stream.
// Optional beat counter is enabled by defining FIFO_RD_CNT_EN.
module fifo_stream_reader #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data_out,
   output logic             fifo_r_en,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_data,
   input  logic             m_ready,
   output logic             idle
`ifdef FIFO_RD_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] beat_count
`endif
);

   logic [1:0]       occ_q, occ_d;
   logic             inflight_q, inflight_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic             pop;
   logic [1:0]       occAfterPop;
   logic [2:0]       occSum;

   // Issue a read only if the word it returns is guaranteed a free buffer slot.
   always_comb begin
      pop         = (occ_q != 2'd0) && m_ready;
      occSum      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
      occAfterPop = occ_q - {1'b0, pop};
      fifo_r_en   = rst_n && en && !fifo_empty && (occSum <= 3'd1);
      occ_d       = occSum[1:0];
      inflight_d  = fifo_r_en;
      head_d      = head_q;
      tail_d      = tail_q;
      if (pop) begin
         head_d = tail_q;
      end
      if (inflight_q) begin
         if (occAfterPop == 2'd0) begin
            head_d = fifo_data_out;
         end else begin
            tail_d = fifo_data_out;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   assign m_valid = (occ_q != 2'd0);
   assign m_data  = head_q;
   assign idle    = (occ_q == 2'd0) && !inflight_q;

   occNoOverflow: assert property (@(posedge clk) disable iff (!rst_n) occSum <= 3'd2);

`ifdef FIFO_RD_CNT_EN
   logic [CNT_WIDTH-1:0] beatCount_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beatCount_q <= '0;
      end else if (pop) begin
         beatCount_q <= beatCount_q + CNT_WIDTH'(1);
      end
   end

   assign beat_count = beatCount_q;
`else
   // CNT_WIDTH sizes only the beat counter; keep it referenced in this build.
   if (CNT_WIDTH < 1) begin : gInvalidCntWidth
   end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO read port and an in-order scoreboard.
// Define FIFO_RD_CNT_EN to also check beat_count.
module tb_fifo_stream_reader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       fifo_empty;
   logic [7:0] fifo_data_out;
   logic       fifo_r_en;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_ready;
   logic       idle;
`ifdef FIFO_RD_CNT_EN
   logic [15:0] beat_count;
`endif

   logic [7:0] mem [0:255];
   int wrPtr = 0, rdPtr = 0, expRd = 0;
   int errorCount = 0, checkCount = 0, popCount = 0, readCount = 0;
   int popBase, readBase;
   logic rdFlag = 1'b0, prevValid = 1'b0, prevReady = 1'b0;
   logic [7:0] prevData = 8'h00;

   fifo_stream_reader #(.WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .fifo_empty(fifo_empty),
      .fifo_data_out(fifo_data_out),
      .fifo_r_en(fifo_r_en),
      .m_valid(m_valid),
      .m_data(m_data),
      .m_ready(m_ready),
      .idle(idle)
`ifdef FIFO_RD_CNT_EN
      ,
      .beat_count(beat_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic pushWord(input logic [7:0] w);
      mem[wrPtr] = w;
      wrPtr++;
      fifo_empty = 1'b0;
   endtask

   task automatic flushFifo();
      rdPtr      = wrPtr;
      expRd      = wrPtr;
      fifo_empty = 1'b1;
   endtask

   // Negedge: scoreboard pops in FIFO order, check stream stability and read legality.
   task automatic monitorStep();
      rdFlag = fifo_r_en && !fifo_empty;
      if (fifo_empty) checkOutput("readWhileEmpty", fifo_r_en, 1'b0);
      if (rst_n) begin
         if (!en) checkOutput("readWhileDisabled", fifo_r_en, 1'b0);
         if (prevValid && !prevReady) begin
            checkOutput("validHeld", m_valid, 1'b1);
            checkOutput("dataHeld", m_data, prevData);
         end
         if (m_valid && m_ready) begin
            checkOutput("wordExpected", expRd < wrPtr, 1'b1);
            if (expRd < wrPtr) begin
               checkOutput("streamOrder", m_data, mem[expRd]);
               expRd++;
            end
            popCount++;
         end
         prevValid = m_valid;
         prevReady = m_ready;
         prevData  = m_data;
      end else begin
         prevValid = 1'b0;
      end
   endtask

   // One clock: monitor at negedge, then the FIFO answers an accepted read just after the edge.
   task automatic advance();
      @(negedge clk);
      monitorStep();
      @(posedge clk);
      #2;
      if (rdFlag) begin
         fifo_data_out = mem[rdPtr];
         rdPtr++;
         readCount++;
      end
      fifo_empty = (rdPtr == wrPtr);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic applyStimulus(input logic enV, input logic readyV);
      en      = enV;
      m_ready = readyV;
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      advance();
      flushFifo();
      rst_n = 1'b1;
      popBase  = popCount;
      readBase = readCount;
   endtask

   task automatic waitDrain(input int target, input int budget);
      int n = 0;
      while ((popCount < target || !idle) && n < budget) begin
         advance();
         n++;
      end
      checkOutput("drainInTime", n < budget, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      fifo_empty = 1'b1;
      fifo_data_out = 8'h00;
      applyStimulus(1'b1, 1'b1);

      // Reset held with data waiting in the FIFO.
      @(posedge clk);
      #2;
      pushWord(8'h11);
      pushWord(8'h22);
      pushWord(8'h33);
      for (int i = 0; i < 3; i++) begin
         settle();
         checkOutput("rstReadEn", fifo_r_en, 1'b0);
         checkOutput("rstValid", m_valid, 1'b0);
         checkOutput("rstData", m_data, 8'h00);
         checkOutput("rstIdle", idle, 1'b1);
`ifdef FIFO_RD_CNT_EN
         checkOutput("rstBeatCount", beat_count, 16'd0);
`endif
         advance();
      end
      flushFifo();
      rst_n = 1'b1;

      // Single word: two cycles from empty falling to m_valid.
      readBase = readCount;
      pushWord(8'hA5);
      settle();
      checkOutput("singleReadIssued", fifo_r_en, 1'b1);
      checkOutput("singleValidC0", m_valid, 1'b0);
      advance();
      settle();
      checkOutput("singleReadOnce", fifo_r_en, 1'b0);
      checkOutput("singleValidC1", m_valid, 1'b0);
      checkOutput("singleBusy", idle, 1'b0);
      advance();
      settle();
      checkOutput("singleValidC2", m_valid, 1'b1);
      checkOutput("singleData", m_data, 8'hA5);
      advance();
      settle();
      checkOutput("singleValidC3", m_valid, 1'b0);
      checkOutput("singleIdle", idle, 1'b1);
      checkOutput("singleReadCount", readCount - readBase, 1);

      // Burst of 8 with no backpressure: eight back-to-back valid cycles.
      applyReset();
      applyStimulus(1'b1, 1'b1);
      for (int w = 1; w <= 8; w++) pushWord(8'(w));
      for (int i = 0; i < 12; i++) begin
         settle();
         checkOutput("burstReadEn", fifo_r_en, i <= 7);
         checkOutput("burstValid", m_valid, (i >= 2) && (i <= 9));
         if (i >= 2 && i <= 9) checkOutput("burstData", m_data, 8'(i - 1));
         advance();
      end
      checkOutput("burstPops", popCount - popBase, 8);
      checkOutput("burstReads", readCount - readBase, 8);
`ifdef FIFO_RD_CNT_EN
      checkOutput("burstBeatCount", beat_count, 16'd8);
`endif

      // Backpressure: only two reads while m_ready stays low.
      applyReset();
      applyStimulus(1'b1, 1'b0);
      for (int w = 0; w < 6; w++) pushWord(8'(8'h10 + w));
      for (int i = 0; i < 6; i++) begin
         settle();
         checkOutput("bpReadEn", fifo_r_en, i <= 1);
         if (i >= 2) begin
            checkOutput("bpValid", m_valid, 1'b1);
            checkOutput("bpHeadData", m_data, 8'h10);
         end
         advance();
      end
      checkOutput("bpReadsWhileStalled", readCount - readBase, 2);
      applyStimulus(1'b1, 1'b1);
      waitDrain(popBase + 6, 30);
      checkOutput("bpPops", popCount - popBase, 6);
      checkOutput("bpReads", readCount - readBase, 6);

      // Enable dropped after the third read for five cycles.
      applyReset();
      applyStimulus(1'b1, 1'b1);
      for (int w = 0; w < 8; w++) pushWord(8'(8'h20 + w));
      for (int i = 0; i < 13; i++) begin
         if (i == 3) applyStimulus(1'b0, 1'b1);
         if (i == 8) applyStimulus(1'b1, 1'b1);
         settle();
         if (i <= 2) checkOutput("enReadEn", fifo_r_en, 1'b1);
         if (i == 4) begin
            checkOutput("enInflightValid", m_valid, 1'b1);
            checkOutput("enInflightData", m_data, 8'h22);
         end
         if (i >= 5 && i <= 7) checkOutput("enDrained", m_valid, 1'b0);
         if (i == 8) begin
            checkOutput("enResumeReadEn", fifo_r_en, 1'b1);
            checkOutput("enReadsBeforeResume", readCount - readBase, 3);
         end
         advance();
      end
      waitDrain(popBase + 8, 40);
      checkOutput("enPops", popCount - popBase, 8);
      checkOutput("enReads", readCount - readBase, 8);

      // Reset while one word is buffered and another is in flight.
      applyReset();
      applyStimulus(1'b1, 1'b0);
      for (int w = 0; w < 4; w++) pushWord(8'(8'h30 + w));
      advance();
      advance();
      rst_n = 1'b0;
      settle();
      checkOutput("midPreValid", m_valid, 1'b1);
      checkOutput("midPreIdle", idle, 1'b0);
      advance();
      flushFifo();
      rst_n = 1'b1;
      settle();
      checkOutput("midValid", m_valid, 1'b0);
      checkOutput("midIdle", idle, 1'b1);
      checkOutput("midData", m_data, 8'h00);
      checkOutput("midReadEn", fifo_r_en, 1'b0);
`ifdef FIFO_RD_CNT_EN
      checkOutput("midBeatCount", beat_count, 16'd0);
`endif
      popBase = popCount;
      applyStimulus(1'b1, 1'b1);
      pushWord(8'h40);
      pushWord(8'h41);
      pushWord(8'h42);
      waitDrain(popBase + 3, 20);
      checkOutput("midPops", popCount - popBase, 3);
      checkOutput("allConsumed", expRd, wrPtr);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
